// File: rtl/gen_pad_reader.sv
// Mega Drive 3/6-button pad reader: drives TH through the 8-phase select
// sequence, samples the pad lines per phase and publishes decoded buttons.
module gen_pad_reader #(
   parameter int SETTLE = 8,
   parameter int GAP    = 12000
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       CE,
   input  logic       START,
   input  logic [5:0] PAD_IN,
   output logic       PAD_TH,
   output logic       BUSY,
   output logic       VALID,
   output logic       PRESENT,
   output logic       SIX_BTN,
   output logic       P_UP,
   output logic       P_DOWN,
   output logic       P_LEFT,
   output logic       P_RIGHT,
   output logic       P_A,
   output logic       P_B,
   output logic       P_C,
   output logic       P_START,
   output logic       P_X,
   output logic       P_Y,
   output logic       P_Z,
   output logic       P_MODE
);

   localparam int CW = $clog2(GAP + 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
   localparam logic [CW-1:0] GAP_LAST    = CW'(GAP - 1);

   typedef enum logic [1:0] {IDLE, STEP, GAP_WAIT} state_t;

   state_t        state, state_n;
   logic [2:0]    step, step_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          pending, pending_n;
   logic          sample, commit;

   logic [5:0]    sync1, sync2;
   logic [5:0]    raw;

   // Shadow bits, order {mode,z,y,x,start,c,b,a,right,left,down,up}
   logic [11:0]   sh_btn;
   logic          sh_pres, sh_six;
   logic [11:0]   btn;
   logic          valid_q, present_q, six_q;

   // Pad lines are asynchronous to CLK; the synchronizer runs every cycle
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1 <= 6'h3F;
         sync2 <= 6'h3F;
      end else begin
         sync1 <= PAD_IN;
         sync2 <= sync1;
      end
   end

   assign raw = ~sync2;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= IDLE;
         step    <= 3'd0;
         cnt     <= '0;
         pending <= 1'b0;
      end else begin
         state   <= state_n;
         step    <= step_n;
         cnt     <= cnt_n;
         pending <= pending_n;
      end
   end

   always_comb begin
      state_n   = state;
      step_n    = step;
      cnt_n     = cnt;
      pending_n = pending;
      sample    = 1'b0;
      commit    = 1'b0;
      if (CE) begin
         case (state)
            IDLE: begin
               if (START || pending) begin
                  pending_n = 1'b0;
                  step_n    = 3'd0;
                  cnt_n     = '0;
                  state_n   = STEP;
               end
            end
            STEP: begin
               if (START) pending_n = 1'b1;
               if (cnt == SETTLE_LAST) begin
                  sample = 1'b1;
                  cnt_n  = '0;
                  step_n = step + 3'd1;
                  if (step == 3'd7) begin
                     commit  = 1'b1;
                     state_n = GAP_WAIT;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            GAP_WAIT: begin
               if (START) pending_n = 1'b1;
               if (cnt == GAP_LAST) begin
                  cnt_n   = '0;
                  state_n = IDLE;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign PAD_TH = (state == STEP) ? ~step[0] : 1'b1;
   assign BUSY   = (state != IDLE);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sh_btn  <= 12'h000;
         sh_pres <= 1'b0;
         sh_six  <= 1'b0;
      end else if (sample) begin
         case (step)
            3'd0: begin
               sh_btn[3:0] <= raw[3:0];
               sh_btn[5]   <= raw[4];
               sh_btn[6]   <= raw[5];
            end
            3'd1: begin
               // TH low on any Mega Drive pad forces D3/D2 low
               sh_pres   <= (sync2[3:2] == 2'b00);
               sh_btn[4] <= raw[4];
               sh_btn[7] <= raw[5];
            end
            3'd5: sh_six <= sh_pres & (sync2[3:0] == 4'b0000);
            3'd6: begin
               sh_btn[10] <= raw[0];
               sh_btn[9]  <= raw[1];
               sh_btn[8]  <= raw[2];
               sh_btn[11] <= raw[3];
            end
            default: ;
         endcase
      end
   end

   // Results move only on commit so a partial sequence never leaks out
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         btn       <= 12'h000;
         present_q <= 1'b0;
         six_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         valid_q <= commit;
         if (commit) begin
            present_q <= sh_pres;
            six_q     <= sh_six;
            if (!sh_pres)
               btn <= 12'h000;
            else if (sh_six)
               btn <= sh_btn;
            else
               btn <= {4'b0000, sh_btn[7:0]};
         end
      end
   end

   assign VALID   = valid_q;
   assign PRESENT = present_q;
   assign SIX_BTN = six_q;
   assign {P_MODE, P_Z, P_Y, P_X, P_START, P_C, P_B, P_A,
           P_RIGHT, P_LEFT, P_DOWN, P_UP} = btn;

endmodule

// File: tb/tb_gen_pad_reader.sv
// Bench for gen_pad_reader: behavioural pad model, directed polls, and a
// monitor that checks every VALID against a queue of expected results.
module tb_gen_pad_reader;

   localparam int SETTLE  = 8;
   localparam int GAP     = 200;
   localparam int LAT     = 8 * SETTLE;
   localparam int SPACING = 8 * SETTLE + GAP + 1;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       CE = 1'b0;
   logic       START = 1'b0;
   logic [5:0] PAD_IN;
   logic       PAD_TH, BUSY, VALID, PRESENT, SIX_BTN;
   logic       P_UP, P_DOWN, P_LEFT, P_RIGHT, P_A, P_B, P_C, P_START;
   logic       P_X, P_Y, P_Z, P_MODE;

   gen_pad_reader #(.SETTLE(SETTLE), .GAP(GAP)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .START(START), .PAD_IN(PAD_IN),
      .PAD_TH(PAD_TH), .BUSY(BUSY), .VALID(VALID), .PRESENT(PRESENT),
      .SIX_BTN(SIX_BTN), .P_UP(P_UP), .P_DOWN(P_DOWN), .P_LEFT(P_LEFT),
      .P_RIGHT(P_RIGHT), .P_A(P_A), .P_B(P_B), .P_C(P_C), .P_START(P_START),
      .P_X(P_X), .P_Y(P_Y), .P_Z(P_Z), .P_MODE(P_MODE)
   );

   // ---------------- clock / CE ----------------
   always #5 CLK = ~CLK;

   int ce_ticks = 0;
   always @(posedge CLK) if (CE) ce_ticks <= ce_ticks + 1;

   initial begin
      forever begin
         @(negedge CLK);
         CE = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- pad model ----------------
   // pad_type: 0 none, 1 three-button, 2 six-button
   // pad_btn order {mode,z,y,x,start,c,b,a,right,left,down,up}, 1 = pressed
   logic [1:0]  pad_type = 2'd0;
   logic [11:0] pad_btn  = 12'h000;
   logic [2:0]  ph = 3'd0;
   logic        th_d = 1'b1;
   int          hi_cnt = 0;
   logic [5:0]  pr;

   always @(posedge CLK) begin
      th_d <= PAD_TH;
      if (PAD_TH != th_d) ph <= ph + 3'd1;
      else if (hi_cnt > 150) ph <= 3'd0;
      if (PAD_TH) hi_cnt <= hi_cnt + 1;
      else hi_cnt <= 0;
   end

   always_comb begin
      pr = 6'h00;
      if (pad_type != 2'd0) begin
         if (PAD_TH) begin
            if (pad_type == 2'd2 && ph == 3'd6)
               pr = {pad_btn[6], pad_btn[5], pad_btn[11], pad_btn[8], pad_btn[9], pad_btn[10]};
            else
               pr = {pad_btn[6], pad_btn[5], pad_btn[3:0]};
         end else begin
            if (pad_type == 2'd2 && ph == 3'd5)
               pr = {pad_btn[7], pad_btn[4], 4'b1111};
            else if (pad_type == 2'd2 && ph == 3'd7)
               pr = {pad_btn[7], pad_btn[4], 4'b0000};
            else
               pr = {pad_btn[7], pad_btn[4], 2'b11, pad_btn[1:0]};
         end
      end
      PAD_IN = ~pr;
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad = 0;
   logic [13:0] exp_q[$];
   int          tick_q[$];
   int  vld_seen = 0;
   int  prev_valid_tick = -1;
   bit  spacing_en = 1'b0;
   bit  check_low = 1'b0;
   logic [13:0] act;

   assign act = {PRESENT, SIX_BTN, P_MODE, P_Z, P_Y, P_X, P_START, P_C, P_B,
                 P_A, P_RIGHT, P_LEFT, P_DOWN, P_UP};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout want event", name);
   endtask

   // Monitor: pops one expectation per VALID; VALID must drop after one cycle
   always @(negedge CLK) begin
      if (check_low) begin
         check("valid_width", {31'd0, VALID}, 32'd0);
         check_low = 1'b0;
      end else if (RESET_N && VALID) begin
         if (exp_q.size() == 0) begin
            fail_now("unexpected_valid");
         end else begin
            logic [13:0] e;
            int t;
            e = exp_q.pop_front();
            t = tick_q.pop_front();
            check("result", {18'd0, act}, {18'd0, e});
            if (t >= 0) check("latency", ce_ticks, t);
         end
         if (spacing_en && prev_valid_tick >= 0)
            check("spacing", ce_ticks - prev_valid_tick, SPACING);
         prev_valid_tick = ce_ticks;
         vld_seen++;
         check_low = 1'b1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      int g = 0;
      @(negedge CLK);
      while (BUSY && g < 5000) begin
         @(negedge CLK);
         g++;
      end
      if (BUSY) fail_now("wait_idle");
   endtask

   // Raises START until one CE edge takes it; returns that edge's tick number
   task automatic issue_start(output int n);
      int g = 0;
      @(negedge CLK);
      START = 1'b1;
      do begin
         @(posedge CLK);
         g++;
      end while (!CE && g < 100);
      @(negedge CLK);
      n = ce_ticks;
      START = 1'b0;
   endtask

   task automatic wait_valids(input int target, input int budget);
      int g = 0;
      while (vld_seen < target && g < budget) begin
         @(negedge CLK);
         g++;
      end
      if (vld_seen < target) fail_now("valid_arrival");
   endtask

   task automatic wait_ticks(input int t);
      int g = 0;
      int t0;
      t0 = ce_ticks;
      while (ce_ticks - t0 < t && g < 4 * t + 100) begin
         @(negedge CLK);
         g++;
      end
   endtask

   // TH must read 1,0,1,0,1,0,1,0 for SETTLE ticks each, then 1
   task automatic check_th_seq(input int n);
      int last = -1;
      int errs = 0;
      int g = 0;
      int j;
      logic want, first_got, first_want;
      first_got = 1'b0;
      first_want = 1'b0;
      while (ce_ticks - n <= LAT && g < 2000) begin
         j = ce_ticks - n;
         if (j != last) begin
            want = (j >= LAT) ? 1'b1 : (((j / SETTLE) % 2) == 0);
            if (PAD_TH !== want) begin
               if (errs == 0) begin
                  first_got = PAD_TH;
                  first_want = want;
               end
               errs++;
            end
            last = j;
         end
         @(negedge CLK);
         g++;
      end
      total++;
      if (errs != 0 || last != LAT) begin
         bad++;
         $display("FAIL th_seq: got th=%0b (errors=%0d last=%0d) want th=%0b", first_got, errs, last, first_want);
      end
   endtask

   task automatic run_seq(input logic [1:0] ptype, input logic [11:0] press,
                          input logic [13:0] want, input bit trace_th);
      int n;
      int target;
      pad_type = ptype;
      pad_btn  = press;
      wait_idle();
      target = vld_seen + 1;
      issue_start(n);
      exp_q.push_back(want);
      tick_q.push_back(n + LAT);
      if (trace_th) check_th_seq(n);
      wait_valids(target, 2000);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int base;
      int errs;
      int t0;
      int g;

      // Reset / idle
      repeat (3) @(negedge CLK);
      #1;
      check("reset_outputs", {16'd0, PAD_TH, BUSY, act}, {16'd0, 1'b1, 1'b0, 14'h0000});
      check("reset_valid", {31'd0, VALID}, 32'd0);
      @(negedge CLK);
      RESET_N = 1'b1;

      errs = 0;
      g = 0;
      t0 = ce_ticks;
      while (ce_ticks - t0 < 20000 && g < 40000) begin
         @(negedge CLK);
         if (PAD_TH !== 1'b1 || BUSY !== 1'b0 || VALID !== 1'b0 || act !== 14'h0000)
            errs++;
         g++;
      end
      check("idle_quiet", errs, 0);

      // 6-button pad: A + Z + LEFT, TH sequence traced
      run_seq(2'd2, 12'h414, 14'h3414, 1'b1);
      // 6-button pad: MODE + X + Y + C + UP
      run_seq(2'd2, 12'hB41, 14'h3B41, 1'b0);
      // 6-button pad: UP + DOWN + START
      run_seq(2'd2, 12'h083, 14'h3083, 1'b0);
      // 3-button pad with X pressed: X never reported, no six flag
      run_seq(2'd1, 12'h1A8, 14'h20A8, 1'b0);
      // No pad attached
      run_seq(2'd0, 12'hFFF, 14'h0000, 1'b0);

      // START held: back-to-back polls, one trailing poll from pending
      pad_type = 2'd2;
      pad_btn  = 12'hB41;
      wait_idle();
      base = vld_seen;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(14'h3B41);
         tick_q.push_back(-1);
      end
      prev_valid_tick = -1;
      spacing_en = 1'b1;
      @(negedge CLK);
      START = 1'b1;
      wait_valids(base + 3, 4000);
      START = 1'b0;
      wait_valids(base + 4, 2000);
      wait_ticks(GAP + 3 * LAT);
      spacing_en = 1'b0;
      check("held_count", vld_seen - base, 4);

      // Two START pulses during GAP_WAIT merge into one extra poll
      pad_type = 2'd1;
      pad_btn  = 12'h061;
      wait_idle();
      base = vld_seen;
      issue_start(n);
      exp_q.push_back(14'h2061);
      tick_q.push_back(n + LAT);
      exp_q.push_back(14'h2061);
      tick_q.push_back(-1);
      wait_valids(base + 1, 2000);
      spacing_en = 1'b1;
      repeat (10) @(negedge CLK);
      check("busy_in_gap", {31'd0, BUSY}, 32'd1);
      START = 1'b1;
      repeat (4) @(negedge CLK);
      START = 1'b0;
      repeat (20) @(negedge CLK);
      START = 1'b1;
      repeat (4) @(negedge CLK);
      START = 1'b0;
      wait_valids(base + 2, 2000);
      wait_ticks(GAP + 3 * LAT);
      spacing_en = 1'b0;
      check("merge_count", vld_seen - base, 2);

      // Reset mid-sequence (k=4): outputs cleared immediately
      run_seq(2'd2, 12'h414, 14'h3414, 1'b0);
      wait_idle();
      pad_btn = 12'hB41;
      issue_start(n);
      g = 0;
      while (ce_ticks < n + 4 * SETTLE + 4 && g < 1000) begin
         @(negedge CLK);
         g++;
      end
      check("pre_reset_th_k4", {31'd0, PAD_TH}, 32'd1);
      check("pre_reset_busy", {31'd0, BUSY}, 32'd1);
      RESET_N = 1'b0;
      #1;
      check("async_reset_outputs", {16'd0, PAD_TH, BUSY, act}, {16'd0, 1'b1, 1'b0, 14'h0000});
      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      repeat (200) @(negedge CLK);
      check("post_reset_quiet", {31'd0, VALID}, 32'd0);
      run_seq(2'd2, 12'h9C2, 14'h39C2, 1'b1);

      wait_ticks(20);
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gen_pad_reader.md
Name: gen_pad_reader

Overview:
- Host-side reader for a physical Mega Drive 3/6-button pad attached to an external connector (SNAC).
- Drives the pad's TH select line through the standard 8-phase select sequence and samples the six pad data lines in each phase.
- Decodes the samples into active-high button bits, presence and 6-button flags.
- Output feeds the console I/O port's P1_*/P2_* inputs in place of USB joystick bits. One instance per physical port.

Parameters:
- SETTLE, 8: CE ticks between a TH edge and the data sample (line settle time); range 2..255.
- GAP, 12000: CE ticks TH is held high after a sequence before the next may start; must exceed the pad's ~1.5 ms phase-counter timeout.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- CE  in  1  clock enable; all timing counts CE ticks
- START  in  1  poll request, sampled on CE; a pulse or a held level both work
- PAD_IN  in  6  raw pad lines, active-low, [0]=D0 .. [3]=D3, [4]=TL, [5]=TR
- PAD_TH  out  1  TH select driven to pad
- BUSY  out  1  high from sequence start through end of GAP
- VALID  out  1  one-CLK pulse when result outputs update
- PRESENT  out  1  pad detected in last poll
- SIX_BTN  out  1  6-button pad detected in last poll
- P_UP, P_DOWN, P_LEFT, P_RIGHT, P_A, P_B, P_C, P_START, P_X, P_Y, P_Z, P_MODE  out  1 each  active-high buttons

Behaviour:
- Reset values (asynchronous on RESET_N low, including mid-sequence):
  - PAD_TH=1; BUSY=0, VALID=0, PRESENT=0, SIX_BTN=0; all P_* = 0.
  - FSM in IDLE; counters cleared; pending flag cleared.
- FSM states: IDLE, STEP, GAP_WAIT. All transitions and counting occur only on CLK edges with CE=1. VALID is the only exception (see below).
- IDLE:
  - PAD_TH=1.
  - On CE with START=1 or pending=1: clear pending, set step=0, clear the tick counter, set BUSY=1, go to STEP.
- STEP, step index k=0..7:
  - PAD_TH = ~k[0], so k even drives TH high and k odd drives TH low.
  - The tick counter counts CE ticks from 0. At count SETTLE-1 the FSM samples raw = ~PAD_IN into a shadow register set.
  - Sampling rules per k:
    - k=0: up=raw[0], down=raw[1], left=raw[2], right=raw[3], B=raw[4], C=raw[5].
    - k=1: pres = (PAD_IN[3:2]==2'b00); A=raw[4], START=raw[5]. raw[1:0] is ignored.
    - k=2, 3, 4: no sample.
    - k=5: six = pres & (PAD_IN[3:0]==4'b0000).
    - k=6: Z=raw[0], Y=raw[1], X=raw[2], MODE=raw[3].
    - k=7: no sample.
  - After sampling, the counter clears and k increments.
  - After k=7: PAD_TH=1, commit, go to GAP_WAIT.
- Commit:
  - PRESENT=pres and SIX_BTN=six.
  - If pres=0, all P_* = 0.
  - Otherwise the 3-button bits come from the shadows. X/Y/Z/MODE take their shadows only if six=1, else 0.
  - All outputs update in the same CLK edge.
  - VALID=1 for exactly that one CLK cycle and deasserts on the next CLK edge regardless of CE.
- GAP_WAIT:
  - PAD_TH=1; counts GAP CE ticks, then BUSY=0 and go to IDLE.
  - START seen while BUSY sets pending, which holds at most one request. Further requests merge into it.
  - A pending request starts a new sequence on the first CE after IDLE is entered. The GAP is never shortened.
- Latency from START to VALID: 1 + 8*SETTLE CE ticks.
- Result outputs are stable between VALID pulses. A partial sequence never alters them.
- Counter width is $clog2(GAP+1) bits, shared by STEP and GAP_WAIT.
- CE=0 freezes all state and PAD_TH.
- PAD_IN is asynchronous: pass it through a 2-flop synchronizer on CLK before sampling. The synchronizer delay is absorbed by SETTLE≥2.

Test Plan:
1. Reset/idle: RESET_N=0 for 3 CLK then release, no START -> PAD_TH=1, BUSY=0, all outputs 0 for 20000 CE ticks.
2. 6-button pad model with A+Z+LEFT pressed, START pulse (SETTLE=8) -> PAD_TH toggles 1,0,1,0,1,0,1,0 with 8 CE ticks each. VALID at tick 65. PRESENT=1, SIX_BTN=1, P_A=P_Z=P_LEFT=1, others 0.
3. 3-button pad model (phase k=5 lower nibble shows D1..D0 as up/down, not 0000) with X-line noise -> SIX_BTN=0, P_X/P_Y/P_Z/P_MODE=0, 3-button bits correct.
4. No pad (PAD_IN=6'h3F constantly) -> PRESENT=0, all P_*=0, VALID still pulses once.
5. START held high continuously -> successive VALID pulses exactly 64+GAP+1 CE ticks apart. A second START pulse during GAP_WAIT yields one extra sequence right after GAP, not two.
6. RESET_N asserted at k=4 -> PAD_TH=1 and outputs cleared immediately (asynchronous). After release, the next START produces a complete correct sequence from k=0.
